pipe_rr_arbiter: RTL
====================

# pipe_rr_arbiter

Round-robin arbiter sharing one fixed-depth register delay pipeline between NREQ requesters. Each cycle it grants at most one valid requester, loads that word plus its requester ID into stage 0, and shifts the pipeline. The output end carries a valid/ready handshake. Backpressure stalls the whole pipeline. The block sits in front of a consumer that needs delayed, tagged data from several sources.

## Interface
- WIDTH, 8, data width per word
- FIFO_LEN, 2, pipeline depth in stages (>=1)
- NREQ, 4, number of requesters (>=1)
- IDW, $clog2(NREQ) (min 1), requester ID width (derived)
- CW, $clog2(FIFO_LEN+1), occupancy counter width (derived)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester word valid
- req_data  in  NREQ x WIDTH  per-requester word
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] && req_ready[i]
- o_valid  out  1  last stage holds a word
- o_data  out  WIDTH  last-stage data
- o_id  out  IDW  requester index of last-stage word
- o_ready  in  1  consumer accepts the output word
- o_count  out  CW  number of valid stages in the pipeline

## Operation
- State per stage: valid bit, WIDTH data, IDW id. Plus a round-robin pointer ptr (IDW bits) and the o_count register.
- advance = !o_valid || o_ready.
- Grant: search req_valid starting at ptr, wrapping modulo NREQ. The first set index wins. req_ready[win] = advance && !rst. All other req_ready bits are 0. The grant is combinational, with no registered request.
- On advance:
  - stage0 takes {1, req_data[win], win} if any req_valid, else a bubble {0, 0, 0}.
  - stage[k] takes stage[k-1] for k>=1. The output word is consumed or dropped as a bubble.
- On !advance: every stage holds, bubbles included. There is no bubble compaction.
- ptr becomes (win+1) mod NREQ only on an accepted transfer. Otherwise ptr holds. With NREQ=1, ptr stays 0.
- o_count rules:
  - +1 on accept only.
  - -1 on o_valid && o_ready only.
  - Unchanged when both or neither occur.
  - Never exceeds FIFO_LEN.
- o_data and o_id are 0 whenever o_valid=0.
- Requesters hold req_valid/req_data until accepted. The arbiter does not check this.

## Timing
- Reset (async, effective immediately): all stage valid/data/id = 0, ptr = 0, o_count = 0. Therefore o_valid=0, o_data=0, o_id=0, and req_ready=0 while rst is high.
- First grant is possible in the first cycle after rst deasserts.
- Latency with no stalls: a word accepted on edge E appears at the output after edge E+FIFO_LEN-1.
  - It is visible for exactly one cycle if o_ready=1.
  - FIFO_LEN=1: visible in the cycle right after acceptance.
- Throughput: one word per cycle when o_ready stays high.
- Stalls: each cycle with o_valid=1 and o_ready=0 adds one cycle of latency to every in-flight word and forces all req_ready to 0.
- A stall cycle where o_valid=0 is not a stall: advance=1 regardless of o_ready.
- Simultaneous accept and output in one cycle: o_count unchanged; both words move.
- Reset mid-operation discards all in-flight words. No o_valid pulse occurs for them after release.

## Test plan
1. Reset: assert rst asynchronously between edges with 2 words in flight. Required immediately: o_valid=0, o_data=0, o_id=0, o_count=0, req_ready=0. After release: no stale output, and ptr=0, so the next grant with all requesters valid goes to requester 0.
2. Single transfer (WIDTH=8, FIFO_LEN=2, NREQ=4), o_ready=1: req_valid=4'b0010, req_data[1]=0xA5. Required: req_ready=4'b0010 in the same cycle; o_valid=1, o_data=0xA5, o_id=1 for exactly one cycle, 2 cycles after the handshake cycle; o_count goes 1 then 0.
3. Fairness: all 4 requesters continuously valid with data 0x10+i, o_ready=1, for 8 cycles. Required: o_id sequence 0,1,2,3,0,1,2,3 and data matching; o_count steady at 2.
4. Wrap and skip: req_valid=4'b1100 grants 2, then 3. Then req_valid=4'b0101 must grant 0 (ptr wrapped to 0), then 2.
5. Backpressure: stream from requester 3, drop o_ready for 3 cycles while o_valid=1. Required: o_data/o_id held, req_ready=0, o_count held at 2. After release, no loss, duplication, or reordering.
6. Bubble/stall: a single word in stage 0 with o_ready=0 and o_valid=0. The pipeline must still advance. The word must emerge at the normal latency.

Source files
------------

// File: rtl/pipe_rr_arbiter.sv
// pipe_rr_arbiter: round-robin arbiter feeding a stallable, ID-tagged register delay pipeline
module pipe_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int FIFO_LEN = 2,
    parameter int NREQ     = 4,
    parameter int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int CW       = $clog2(FIFO_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    output logic [IDW-1:0]        o_id,
    input  logic                  o_ready,
    output logic [CW-1:0]         o_count
);
    logic [FIFO_LEN-1:0]            vld_q, vld_d;
    logic [FIFO_LEN-1:0][WIDTH-1:0] data_q, data_d;
    logic [FIFO_LEN-1:0][IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]                 ptr_q, ptr_d, win, cand;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           any, advance, accept, pop;

    assign o_valid = vld_q[FIFO_LEN-1];
    assign o_data  = o_valid ? data_q[FIFO_LEN-1] : '0;
    assign o_id    = o_valid ? id_q[FIFO_LEN-1] : '0;
    assign o_count = cnt_q;
    assign advance = !o_valid || o_ready;
    assign accept  = any && advance;
    assign pop     = o_valid && o_ready;

    // first valid requester at or after ptr, wrapping modulo NREQ
    always_comb begin
        any  = 1'b0;
        win  = ptr_q;
        cand = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr_q) + i) % NREQ);
            if (!any && req_valid[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
    end

    // one-hot grant only when the pipeline can take a word
    always_comb begin
        req_ready = '0;
        if (accept && !rst) req_ready[win] = 1'b1;
    end

    // shift on advance, hold everything (bubbles included) on a stall
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        id_d   = id_q;
        if (advance) begin
            for (int k = FIFO_LEN - 1; k > 0; k--) begin
                vld_d[k]  = vld_q[k-1];
                data_d[k] = data_q[k-1];
                id_d[k]   = id_q[k-1];
            end
            vld_d[0]  = any;
            data_d[0] = any ? req_data[int'(win)*WIDTH +: WIDTH] : '0;
            id_d[0]   = any ? win : '0;
        end
        ptr_d = accept ? ((win == IDW'(NREQ - 1)) ? '0 : win + 1'b1) : ptr_q;
        cnt_d = cnt_q + CW'(accept) - CW'(pop);
    end

    // state registers, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            data_q <= '0;
            id_q   <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule
